// File: rtl/tone_env_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_env_pkg
// Description : Shared envelope FSM state encodings and prescaler divide helper.
// Revision    : 1.0  initial release
// ============================================================================
package tone_env_pkg;

    localparam int ENV_STATE_W = 3;
    typedef logic [ENV_STATE_W-1:0] env_state_t;

    localparam env_state_t ENV_IDLE    = 3'd0;
    localparam env_state_t ENV_ATTACK  = 3'd1;
    localparam env_state_t ENV_DECAY   = 3'd2;
    localparam env_state_t ENV_SUSTAIN = 3'd3;
    localparam env_state_t ENV_RELEASE = 3'd4;

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_envelope_pwm_if.sv
`default_nettype none
// ============================================================================
// Module      : tone_env_if
// Description : Control/audio bundle between song player (master) and envelope stage (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface tone_env_if #(
    parameter int PWM_BITS = 8
);
    logic                enable;
    logic                tone_in;
    logic                note_start;
    logic                note_gate;
    logic                audio_pwm;
    logic                aud_sd;
    logic [PWM_BITS-1:0] env_level;
    logic                busy;

    modport master (
        output enable, tone_in, note_start, note_gate,
        input  audio_pwm, aud_sd, env_level, busy
    );

    modport slave (
        input  enable, tone_in, note_start, note_gate,
        output audio_pwm, aud_sd, env_level, busy
    );
endinterface
`default_nettype wire

// File: rtl/env_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : env_tick_gen
// Description : Envelope-rate prescaler; one-cycle tick every TICK_DIV clocks, sync clear.
// Revision    : 1.0  initial release
// ============================================================================
module env_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);
endmodule
`default_nettype wire

// File: rtl/tone_envelope_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tone_envelope_pwm
// Description : ADSR amplitude envelope applied to a square tone, PWM 1-bit output.
//               ENV_SUSTAIN_EN defined: organ-like hold at SUSTAIN_LEVEL;
//               undefined: percussive decay straight to silence.
// Revision    : 1.0  initial release
// ============================================================================
module tone_envelope_pwm
    import tone_env_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int ENV_TICK_HZ   = 1_000,
    parameter int PWM_BITS      = 8,
    parameter int ATTACK_STEP   = 16,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 128,
    parameter int RELEASE_STEP  = 4
) (
    input  logic       clock,
    input  logic       reset,
    tone_env_if.slave  bus
);
    localparam int TICK_DIV = tick_div(CLK_HZ, ENV_TICK_HZ);

    localparam logic [PWM_BITS-1:0] LMAX     = '1;
    localparam logic [PWM_BITS:0]   ATK_STEP = (PWM_BITS+1)'(ATTACK_STEP);
    localparam logic [PWM_BITS-1:0] DEC_STEP = PWM_BITS'(DECAY_STEP);
    localparam logic [PWM_BITS-1:0] REL_STEP = PWM_BITS'(RELEASE_STEP);
`ifdef ENV_SUSTAIN_EN
    localparam logic [PWM_BITS-1:0] SUS_LVL   = PWM_BITS'(SUSTAIN_LEVEL);
    localparam logic [PWM_BITS:0]   DEC_FLOOR = (PWM_BITS+1)'(SUSTAIN_LEVEL + DECAY_STEP);
`endif

    generate
        if (TICK_DIV < 2 || SUSTAIN_LEVEL >= (2**PWM_BITS) - 1) begin : g_param_err
            $error("tone_envelope_pwm: TICK_DIV must be >= 2 and SUSTAIN_LEVEL < LMAX");
        end
    endgenerate

    env_state_t          state, next_state;
    logic [PWM_BITS-1:0] level, next_level;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS:0]   attack_sum;
    logic                tone_meta, tone_s;
    logic                tick;
    logic                start;

    // note_start is ignored entirely while disabled, including the prescaler clear
    assign start      = bus.enable & bus.note_start;
    assign attack_sum = {1'b0, level} + ATK_STEP;

    env_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (start),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ENV_IDLE;
            level <= '0;
        end else begin
            state <= next_state;
            level <= next_level;
        end
    end

    always_comb begin
        next_state = state;
        next_level = level;
        if (!bus.enable) begin
            next_state = ENV_IDLE;
            next_level = '0;
        end else if (start) begin
            // retrigger keeps the current level so there is no click
            next_state = ENV_ATTACK;
        end else begin
            case (state)
                ENV_IDLE: begin
                    next_level = '0;
                end
                ENV_ATTACK: begin
                    if (!bus.note_gate) begin
                        next_state = ENV_RELEASE;
                    end else if (tick) begin
                        if (attack_sum >= {1'b0, LMAX}) begin
                            next_level = LMAX;
                            next_state = ENV_DECAY;
                        end else begin
                            next_level = attack_sum[PWM_BITS-1:0];
                        end
                    end
                end
                ENV_DECAY: begin
                    if (!bus.note_gate) begin
                        next_state = ENV_RELEASE;
                    end else if (tick) begin
`ifdef ENV_SUSTAIN_EN
                        if ({1'b0, level} <= DEC_FLOOR) begin
                            next_level = SUS_LVL;
                            next_state = ENV_SUSTAIN;
                        end else begin
                            next_level = level - DEC_STEP;
                        end
`else
                        if (level <= DEC_STEP) begin
                            next_level = '0;
                            next_state = ENV_IDLE;
                        end else begin
                            next_level = level - DEC_STEP;
                        end
`endif
                    end
                end
`ifdef ENV_SUSTAIN_EN
                ENV_SUSTAIN: begin
                    if (!bus.note_gate) begin
                        next_state = ENV_RELEASE;
                    end
                end
`endif
                ENV_RELEASE: begin
                    if (tick) begin
                        if (level <= REL_STEP) begin
                            next_level = '0;
                            next_state = ENV_IDLE;
                        end else begin
                            next_level = level - REL_STEP;
                        end
                    end
                end
                default: begin
                    next_state = ENV_IDLE;
                    next_level = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state != ENV_IDLE);
        bus.env_level = level;
    end

    // two-flop synchroniser, free-running PWM carrier and registered audio output
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tone_meta     <= 1'b0;
            tone_s        <= 1'b0;
            pwm_cnt       <= '0;
            bus.audio_pwm <= 1'b0;
            bus.aud_sd    <= 1'b0;
        end else begin
            tone_meta     <= bus.tone_in;
            tone_s        <= tone_meta;
            pwm_cnt       <= pwm_cnt + 1'b1;
            bus.audio_pwm <= bus.enable & tone_s & (pwm_cnt < level);
            bus.aud_sd    <= bus.enable;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tone_envelope_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_envelope_pwm
// Description : Self-checking bench: tabled envelope trajectory plus directed corner sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tone_envelope_pwm;

    typedef struct {
        int   tick;
        int   level;
        logic busy;
    } env_vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] ref_cnt;
    int         n_cmp = 0;
    int         n_err = 0;
    env_vec_t   tab [8];

    tone_env_if #(.PWM_BITS(8)) bus ();

    tone_envelope_pwm #(
        .CLK_HZ        (1000),
        .ENV_TICK_HZ   (100),
        .PWM_BITS      (8),
        .ATTACK_STEP   (16),
        .DECAY_STEP    (2),
        .SUSTAIN_LEVEL (128),
        .RELEASE_STEP  (4)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // independent free-running counter matching the PWM carrier phase
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_cnt <= 8'd0;
        else        ref_cnt <= ref_cnt + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_note(input logic gate);
        bus.note_start = 1'b1;
        bus.note_gate  = gate;
        @(negedge clk);
        bus.note_start = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        repeat (n * 10) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   prev;
        int   highs;
        logic exp_a, exp_b;

`ifdef ENV_SUSTAIN_EN
        tab[0] = '{1,   16, 1'b1};
        tab[1] = '{2,   32, 1'b1};
        tab[2] = '{15, 240, 1'b1};
        tab[3] = '{16, 255, 1'b1};
        tab[4] = '{17, 253, 1'b1};
        tab[5] = '{79, 129, 1'b1};
        tab[6] = '{80, 128, 1'b1};
        tab[7] = '{90, 128, 1'b1};
`else
        tab[0] = '{1,    16, 1'b1};
        tab[1] = '{15,  240, 1'b1};
        tab[2] = '{16,  255, 1'b1};
        tab[3] = '{17,  253, 1'b1};
        tab[4] = '{79,  129, 1'b1};
        tab[5] = '{80,  127, 1'b1};
        tab[6] = '{143,   1, 1'b1};
        tab[7] = '{144,   0, 1'b0};
`endif

        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.tone_in    = 1'b0;
        bus.note_start = 1'b0;
        bus.note_gate  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_level", bus.env_level, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_audio", bus.audio_pwm, 0);
        check("rst_sd",    bus.aud_sd, 0);

        rst_n      = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);
        check("sd_on", bus.aud_sd, 1);
        check("idle_level", bus.env_level, 0);

        // attack / decay (/ sustain) trajectory
        start_note(1'b1);
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            run_ticks(tab[i].tick - prev);
            prev = tab[i].tick;
            check($sformatf("env_t%0d_level", tab[i].tick), bus.env_level, tab[i].level);
            check($sformatf("env_t%0d_busy",  tab[i].tick), bus.busy, tab[i].busy);
        end

`ifdef ENV_SUSTAIN_EN
        // duty at sustain level 128: 256 cycles of tone_s=1 give 128 highs
        bus.tone_in = 1'b1;
        repeat (2) @(negedge clk);
        highs = 0;
        repeat (256) begin
            @(negedge clk);
            highs += int'(bus.audio_pwm);
        end
        check("duty_128", highs, 128);
        bus.tone_in = 1'b0;
        repeat (12) @(negedge clk);
        check("sustain_hold", bus.env_level, 128);

        bus.note_gate = 1'b0;
        run_ticks(1);
        check("rel_first", bus.env_level, 124);
        run_ticks(31);
        check("rel_end_level", bus.env_level, 0);
        check("rel_end_busy",  bus.busy, 0);
`endif

        // release from 128 to 100, then retrigger continues upward
        start_note(1'b1);
        run_ticks(8);
        check("atk_128", bus.env_level, 128);
        bus.note_gate = 1'b0;
        run_ticks(7);
        check("rel_100", bus.env_level, 100);
        start_note(1'b1);
        check("retrig_hold", bus.env_level, 100);
        check("retrig_busy", bus.busy, 1);
        run_ticks(1);
        check("retrig_116", bus.env_level, 116);
        run_ticks(1);
        check("retrig_132", bus.env_level, 132);
        run_ticks(8);
        check("atk_sat_255", bus.env_level, 255);

        // tone_in -> audio_pwm latency of 3 clocks while level is 255
        bus.tone_in = 1'b1;
        @(negedge clk);
        check("lat_rise_c1", bus.audio_pwm, 0);
        @(negedge clk);
        check("lat_rise_c2", bus.audio_pwm, 0);
        exp_a = (ref_cnt != 8'd255);
        @(negedge clk);
        check("lat_rise_c3", bus.audio_pwm, exp_a);
        bus.tone_in = 1'b0;
        exp_a = (ref_cnt != 8'd255);
        @(negedge clk);
        check("lat_fall_c1", bus.audio_pwm, exp_a);
        exp_b = (ref_cnt != 8'd255);
        @(negedge clk);
        check("lat_fall_c2", bus.audio_pwm, exp_b);
        @(negedge clk);
        check("lat_fall_c3", bus.audio_pwm, 0);

        // enable low forces idle and ignores note_start
        bus.enable = 1'b0;
        @(negedge clk);
        check("dis_level", bus.env_level, 0);
        check("dis_busy",  bus.busy, 0);
        check("dis_audio", bus.audio_pwm, 0);
        check("dis_sd",    bus.aud_sd, 0);
        start_note(1'b1);
        check("dis_start_ignored", bus.busy, 0);
        bus.enable = 1'b1;
        @(negedge clk);

        // note_start wins over gate low; then releases from 0 to idle
        start_note(1'b0);
        check("start_vs_gate_busy", bus.busy, 1);
        run_ticks(1);
        check("start_vs_gate_idle", bus.busy, 0);
        check("start_vs_gate_lvl",  bus.env_level, 0);

        // asynchronous reset mid-note
        start_note(1'b1);
        run_ticks(3);
        check("pre_rst_48", bus.env_level, 48);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", bus.env_level, 0);
        check("async_rst_busy",  bus.busy, 0);
        check("async_rst_audio", bus.audio_pwm, 0);
        check("async_rst_sd",    bus.aud_sd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
